// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state encodings for the game flow and draw stages
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_COUNTDOWN = 3'b001,
        ST_PLAY      = 3'b010,
        ST_PAUSE     = 3'b011,
        ST_OVER      = 3'b100
    } game_state_e;

    localparam logic [2:0] GAME_OVER_STATE = 3'b100;

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - registered 1-bit rising-edge detector, one cycle of latency
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic rise_d;
    logic rise_q;

    always_comb begin
        rise_d = d & ~d_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q    <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            d_q    <= d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game flow FSM with frame counting, countdown and game-over hold
// Optional blinking game-over overlay enabled by defining GAME_OVER_BLINK_EN.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int OVER_HOLD_FRAMES = 120,
    parameter int BLINK_FRAMES     = 30,
    parameter int CNT_W            = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       hit,
    output logic [2:0] game_state,
    output logic       frame_tick,
    output logic [1:0] countdown_val,
    output logic       over_visible
);

    localparam int CNT_MAX = (2 ** CNT_W) - 1;

    if (COUNTDOWN_FRAMES < 1 || COUNTDOWN_FRAMES > CNT_MAX) begin : g_bad_countdown
        $error("COUNTDOWN_FRAMES does not fit in CNT_W");
    end
    if (OVER_HOLD_FRAMES < 1 || OVER_HOLD_FRAMES > CNT_MAX) begin : g_bad_over_hold
        $error("OVER_HOLD_FRAMES does not fit in CNT_W");
    end
    if (BLINK_FRAMES < 1 || BLINK_FRAMES > CNT_MAX) begin : g_bad_blink
        $error("BLINK_FRAMES does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] CD_LAST   = CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] OVER_HOLD = CNT_W'(OVER_HOLD_FRAMES);
    // counter*3 < N  <=>  counter < ceil(N/3); likewise for 2N
    localparam logic [CNT_W-1:0] CD_TH3    = CNT_W'((COUNTDOWN_FRAMES + 2) / 3);
    localparam logic [CNT_W-1:0] CD_TH2    = CNT_W'((2 * COUNTDOWN_FRAMES + 2) / 3);

    logic vsync_rise;
    logic start_rise;
    logic pause_rise;
    logic hit_rise;

    edge_det u_vsync_det (.clk(clk), .rst(rst), .d(vsync),     .rise(vsync_rise));
    edge_det u_start_det (.clk(clk), .rst(rst), .d(start_btn), .rise(start_rise));
    edge_det u_pause_det (.clk(clk), .rst(rst), .d(pause_btn), .rise(pause_rise));
    edge_det u_hit_det   (.clk(clk), .rst(rst), .d(hit),       .rise(hit_rise));

    logic [2:0]       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             frame_tick_d, frame_tick_q;
    logic [1:0]       countdown_d, countdown_q;
    logic             over_visible_d, over_visible_q;

    always_comb begin
        cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        frame_tick_d = vsync_rise;
        state_d      = state_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_rise) state_d = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
                if (frame_tick_q) begin
                    if (cnt_q >= CD_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_PLAY: begin
                cnt_d = '0;
                if (hit_rise)        state_d = ST_OVER;
                else if (pause_rise) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_rise) begin
                    state_d = ST_PLAY;
                    cnt_d   = '0;
                end
            end
            ST_OVER: begin
                // start is only honoured once the hold period has fully elapsed
                if (start_rise && cnt_q == OVER_HOLD) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (frame_tick_q && cnt_q < OVER_HOLD) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        countdown_d = 2'd0;
        if (state_d == ST_COUNTDOWN) begin
            if (cnt_d < CD_TH3)      countdown_d = 2'd3;
            else if (cnt_d < CD_TH2) countdown_d = 2'd2;
            else                     countdown_d = 2'd1;
        end
    end

`ifdef GAME_OVER_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] blink_cnt_d, blink_cnt_q;

    always_comb begin
        blink_cnt_d    = blink_cnt_q;
        over_visible_d = over_visible_q;
        if (state_d != ST_OVER) begin
            blink_cnt_d    = '0;
            over_visible_d = 1'b0;
        end else if (state_q != ST_OVER) begin
            blink_cnt_d    = '0;
            over_visible_d = 1'b1;
        end else if (frame_tick_q) begin
            if (blink_cnt_q >= BLINK_LAST) begin
                blink_cnt_d    = '0;
                over_visible_d = ~over_visible_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) blink_cnt_q <= '0;
        else      blink_cnt_q <= blink_cnt_d;
    end
`else
    always_comb begin
        over_visible_d = (state_d == ST_OVER);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            frame_tick_q   <= 1'b0;
            countdown_q    <= 2'd0;
            over_visible_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            frame_tick_q   <= frame_tick_d;
            countdown_q    <= countdown_d;
            over_visible_q <= over_visible_d;
        end
    end

    assign game_state    = state_q;
    assign frame_tick    = frame_tick_q;
    assign countdown_val = countdown_q;
    assign over_visible  = over_visible_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - directed self-checking bench for game_state_ctrl
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       hit = 1'b0;
    logic [2:0] game_state;
    logic       frame_tick;
    logic [1:0] countdown_val;
    logic       over_visible;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_vis [4];

    always #5 clk = ~clk;

    game_state_ctrl #(
        .COUNTDOWN_FRAMES(6),
        .OVER_HOLD_FRAMES(4),
        .BLINK_FRAMES    (2),
        .CNT_W           (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vsync        (vsync),
        .start_btn    (start_btn),
        .pause_btn    (pause_btn),
        .hit          (hit),
        .game_state   (game_state),
        .frame_tick   (frame_tick),
        .countdown_val(countdown_val),
        .over_visible (over_visible)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        vsync = 1'b1;
        cyc(1);
        vsync = 1'b0;
        cyc(2);
    endtask

    // 0 = start, 1 = pause, 2 = hit
    task automatic press(input int which);
        case (which)
            0: start_btn = 1'b1;
            1: pause_btn = 1'b1;
            default: hit = 1'b1;
        endcase
        cyc(1);
        start_btn = 1'b0;
        pause_btn = 1'b0;
        hit       = 1'b0;
        cyc(1);
    endtask

    initial begin
`ifdef GAME_OVER_BLINK_EN
        exp_vis[0] = 1'b1; exp_vis[1] = 1'b0; exp_vis[2] = 1'b0; exp_vis[3] = 1'b1;
`else
        exp_vis[0] = 1'b1; exp_vis[1] = 1'b1; exp_vis[2] = 1'b1; exp_vis[3] = 1'b1;
`endif
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            vsync     = 1'($urandom);
            start_btn = 1'($urandom);
            pause_btn = 1'($urandom);
            hit       = 1'($urandom);
        end
        cyc(1);
        chk("rst_state", 8'(game_state), 8'h0);
        chk("rst_tick", 8'(frame_tick), 8'h0);
        chk("rst_cd", 8'(countdown_val), 8'h0);
        chk("rst_vis", 8'(over_visible), 8'h0);
        vsync = 0; start_btn = 0; pause_btn = 0; hit = 0;
        cyc(1);
        rst = 1'b1;
        cyc(3);
        chk("idle_after_rst", 8'(game_state), 8'h0);

        press(0);
        chk("cd_enter", 8'(game_state), 8'h1);
        chk("cd_val0", 8'(countdown_val), 8'h3);

        vsync = 1'b1;
        cyc(1);
        chk("tick_lat0", 8'(frame_tick), 8'h0);
        vsync = 1'b0;
        cyc(1);
        chk("tick_pulse", 8'(frame_tick), 8'h1);
        cyc(1);
        chk("tick_one_cycle", 8'(frame_tick), 8'h0);
        chk("cd_val1", 8'(countdown_val), 8'h3);

        press(0);
        press(2);
        press(1);
        chk("cd_ignores_btns", 8'(game_state), 8'h1);
        frame();
        chk("cd_val2", 8'(countdown_val), 8'h2);
        frame();
        chk("cd_val3", 8'(countdown_val), 8'h2);
        frame();
        chk("cd_val4", 8'(countdown_val), 8'h1);
        frame();
        chk("cd_val5", 8'(countdown_val), 8'h1);
        chk("cd_still", 8'(game_state), 8'h1);
        frame();
        chk("play_enter", 8'(game_state), 8'h2);
        chk("play_cd0", 8'(countdown_val), 8'h0);
        chk("play_vis0", 8'(over_visible), 8'h0);

        press(1);
        chk("pause_enter", 8'(game_state), 8'h3);
        press(2);
        chk("pause_ign_hit", 8'(game_state), 8'h3);
        frame();
        press(1);
        chk("pause_exit", 8'(game_state), 8'h2);

        hit = 1'b1;
        pause_btn = 1'b1;
        cyc(1);
        hit = 1'b0;
        pause_btn = 1'b0;
        cyc(1);
        chk("hit_wins", 8'(game_state), 8'h4);
        chk("over_vis_entry", 8'(over_visible), 8'h1);

        frame();
        chk("vis_f1", 8'(over_visible), 8'(exp_vis[0]));
        frame();
        chk("vis_f2", 8'(over_visible), 8'(exp_vis[1]));
        press(0);
        chk("over_early_start", 8'(game_state), 8'h4);
        frame();
        chk("vis_f3", 8'(over_visible), 8'(exp_vis[2]));
        frame();
        chk("vis_f4", 8'(over_visible), 8'(exp_vis[3]));
        chk("over_hold", 8'(game_state), 8'h4);
        frame();
        chk("over_sat", 8'(game_state), 8'h4);

        start_btn = 1'b1;
        cyc(2);
        chk("over_exit", 8'(game_state), 8'h0);
        cyc(5);
        chk("held_start_once", 8'(game_state), 8'h0);
        chk("idle_vis0", 8'(over_visible), 8'h0);
        start_btn = 1'b0;
        cyc(1);

        press(0);
        chk("rearm_start", 8'(game_state), 8'h1);
        frame();
        frame();
        chk("cd_mid", 8'(countdown_val), 8'h2);

        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_state", 8'(game_state), 8'h0);
        chk("async_cd", 8'(countdown_val), 8'h0);
        chk("async_tick", 8'(frame_tick), 8'h0);
        chk("async_vis", 8'(over_visible), 8'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc(3);
        chk("post_async_idle", 8'(game_state), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
